// File: rtl/putc_uart_tx_if.sv
// Character-offer handshake between the CPU putc opcode and the UART transmitter.
interface putc_uart_tx_if;
  logic       putc_valid;
  logic [7:0] putc_data;
  logic       putc_ready;

  modport master (output putc_valid, putc_data, input putc_ready);
  modport slave  (input putc_valid, putc_data, output putc_ready);
endinterface

// File: rtl/putc_uart_tx.sv
// CPU putc character FIFO feeding an 8N1 UART transmitter (LSB first, idle high).
// Frames are 10*CLKS_PER_BIT cycles, separated by a single IDLE cycle when the FIFO has more data.
module putc_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  putc_uart_tx_if.slave putc,
  output logic          tx,
  output logic          busy,
  output logic          overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [AW:0]   FULL      = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_n;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count, count_n;
  logic [CW-1:0] baud;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          ready_r, push, drop, pop, bit_end, tx_n;

  // A full FIFO drops the offer even when the transmitter pops in the same cycle.
  assign push    = putc.putc_valid && (count != FULL);
  assign drop    = putc.putc_valid && (count == FULL);
  assign bit_end = (baud == BAUD_LAST);
  assign putc.putc_ready = ready_r;

  always_comb begin
    count_n = count;
    case ({push, pop})
      2'b10:   count_n = count + 1'b1;
      2'b01:   count_n = count - 1'b1;
      default: count_n = count;
    endcase
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    tx_n    = 1'b1;
    case (state)
      IDLE: if (count != '0) begin
        pop     = 1'b1;
        state_n = START;
      end
      START: begin
        tx_n = 1'b0;
        if (bit_end) state_n = DATA;
      end
      DATA: begin
        tx_n = shift[0];
        if (bit_end && bit_idx == 3'd7) state_n = STOP;
      end
      STOP: if (bit_end) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= putc.putc_data;
  end

  // busy and putc_ready are registered from next-state values so they track state/count exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      ready_r  <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count   <= count_n;
      ready_r <= (count_n != FULL);
      busy    <= (state_n != IDLE) || (count_n != '0);
      if (drop) overflow <= 1'b1;
    end
  end

  // tx follows the current state one cycle late, so every bit keeps its full width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      tx <= tx_n;
      if (pop) begin
        shift   <= mem[rd_ptr];
        baud    <= '0;
        bit_idx <= '0;
      end else if (state != IDLE) begin
        baud <= bit_end ? '0 : baud + 1'b1;
        if (state == DATA && bit_end) begin
          shift   <= {1'b0, shift[7:1]};
          bit_idx <= bit_idx + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_putc_uart_tx.sv
// Directed bench for putc_uart_tx at CLKS_PER_BIT=4, FIFO_DEPTH=8: line patterns, burst, overflow, reset, wrap.
module tb_putc_uart_tx;
  logic clk = 1'b0;
  logic rst_n;
  logic tx, busy, overflow;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  putc_uart_tx_if pif ();

  putc_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .putc(pif), .tx(tx), .busy(busy), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { logic [7:0] ch; logic [9:0] line; } vec_t;
  typedef struct packed { logic [31:0] start; logic [7:0] b; logic ok; } rx_t;

  vec_t       vecs [5];
  rx_t        rxq [$];
  logic [7:0] expq [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [7:0] ch);
    pif.putc_valid = 1'b1;
    pif.putc_data  = ch;
    tick();
    pif.putc_valid = 1'b0;
  endtask

  task automatic wait_low(output int lat);
    lat = 0;
    while (tx !== 1'b0 && lat < 100) begin tick(); lat++; end
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (busy !== 1'b0 && n < budget) begin tick(); n++; end
    check({name, " drain"}, busy, 0);
    tick(); tick();
  endtask

  task automatic check_rx(input string name, input bit b2b);
    check({name, " count"}, rxq.size(), expq.size());
    for (int i = 0; i < expq.size() && i < rxq.size(); i++) begin
      check($sformatf("%s byte%0d", name, i), rxq[i].b, expq[i]);
      check($sformatf("%s frame%0d", name, i), rxq[i].ok, 1);
      if (b2b && i > 0)
        check($sformatf("%s gap%0d", name, i), rxq[i].start - rxq[i-1].start, 41);
    end
  endtask

  // Line monitor: captures 40 cycles per frame, samples mid-bit, checks every bit is flat for 4 cycles.
  initial begin : mon
    logic [39:0] s;
    logic        ab, ok;
    rx_t         r;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx === 1'b0) begin
        s = '1; s[0] = 1'b0; ab = 1'b0; r = '0; r.start = cyc;
        for (int n = 1; n < 40; n++) begin
          @(negedge clk);
          if (rst_n !== 1'b1) begin ab = 1'b1; break; end
          s[n] = tx;
        end
        if (!ab) begin
          ok = (s[3:0] == 4'h0) && (s[39:36] == 4'hF);
          for (int k = 1; k < 9; k++) ok = ok && (s[4*k +: 4] == {4{s[4*k]}});
          for (int k = 0; k < 8; k++) r.b[k] = s[4*(k+1) + 2];
          r.ok = ok;
          rxq.push_back(r);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int         lat;
    logic [9:0] line;
    logic       stable, mid_busy, v;

    // Serial line bit i = line[i]: start, d0..d7, stop.
    vecs[0] = '{ch: 8'h41, line: 10'b1010000010};
    vecs[1] = '{ch: 8'h00, line: 10'b1000000000};
    vecs[2] = '{ch: 8'hFF, line: 10'b1111111110};
    vecs[3] = '{ch: 8'hA5, line: 10'b1101001010};
    vecs[4] = '{ch: 8'h30, line: 10'b1001100000};

    rst_n = 1'b0;
    pif.putc_valid = 1'b0;
    pif.putc_data  = '0;
    tick(); tick();
    check("rst tx", tx, 1);
    check("rst busy", busy, 0);
    check("rst ready", pif.putc_ready, 1);
    check("rst overflow", overflow, 0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) begin
      push(vecs[i].ch);
      wait_low(lat);
      check($sformatf("vec%0d latency", i), lat, 2);
      line = '0; stable = 1'b1; mid_busy = 1'b0;
      for (int s = 0; s < 40; s++) begin
        if (s > 0) tick();
        v = tx;
        if (s % 4 == 0) line[s/4] = v;
        else if (v !== line[s/4]) stable = 1'b0;
        if (s == 20) mid_busy = busy;
      end
      check($sformatf("vec%0d line", i), line, vecs[i].line);
      check($sformatf("vec%0d bit width", i), stable, 1);
      check($sformatf("vec%0d busy mid", i), mid_busy, 1);
      check($sformatf("vec%0d busy end", i), busy, 0);
      tick();
    end

    // Burst of two: one idle cycle between frames.
    rxq.delete(); expq.delete();
    expq.push_back(8'h48); expq.push_back(8'h69);
    push(8'h48); push(8'h69);
    wait_idle("burst", 200);
    check_rx("burst", 1'b1);

    // Ten back-to-back offers: one popped early, eight buffered, tenth dropped.
    rxq.delete(); expq.delete();
    pif.putc_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      pif.putc_data = 8'h61 + 8'(i);
      if (i < 9) expq.push_back(8'h61 + 8'(i));
      tick();
      if (i == 7) check("full ready before", pif.putc_ready, 1);
      if (i == 8) begin
        check("full ready", pif.putc_ready, 0);
        check("full no ovf yet", overflow, 0);
      end
    end
    pif.putc_valid = 1'b0;
    check("full overflow", overflow, 1);
    check("full ready held", pif.putc_ready, 0);
    wait_idle("full", 500);
    check_rx("full", 1'b1);
    check("ovf sticky", overflow, 1);

    // Push while full on the same edge the transmitter pops.
    rst_n = 1'b0; tick(); tick(); rst_n = 1'b1; tick();
    check("pp ovf cleared", overflow, 0);
    rxq.delete(); expq.delete();
    pif.putc_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      pif.putc_data = 8'h70 + 8'(i);
      expq.push_back(8'h70 + 8'(i));
      tick();
    end
    pif.putc_valid = 1'b0;
    check("pp filled", pif.putc_ready, 0);
    check("pp no ovf", overflow, 0);
    repeat (33) tick();
    check("pp still full", pif.putc_ready, 0);
    push(8'hEE);
    check("pp overflow", overflow, 1);
    check("pp count 7", pif.putc_ready, 1);
    wait_idle("pp", 500);
    check_rx("pp", 1'b1);

    // Reset mid-frame discards the frame and the buffered character.
    rxq.delete(); expq.delete();
    push(8'h55); push(8'h7E);
    repeat (16) tick();
    rst_n = 1'b0;
    #1;
    check("midrst tx", tx, 1);
    check("midrst busy", busy, 0);
    check("midrst ready", pif.putc_ready, 1);
    check("midrst overflow", overflow, 0);
    tick(); tick(); tick();
    rst_n = 1'b1;
    expq.push_back(8'h30);
    push(8'h30);
    wait_low(lat);
    check("midrst relatency", lat, 2);
    wait_idle("midrst", 200);
    check_rx("midrst", 1'b0);

    // Twenty single characters wrap the pointers twice.
    rxq.delete(); expq.delete();
    for (int i = 0; i < 20; i++) begin
      expq.push_back(8'(i * 13 + 5));
      push(8'(i * 13 + 5));
      wait_idle($sformatf("wrap%0d", i), 100);
    end
    check_rx("wrap", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
